// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble).
// One ADJUST/SHIFT pair per input bit, then a DONE cycle that publishes
// the result, the leading-zero blank flags and a one-cycle Valid pulse.
module bin2bcd #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic [DIGITS-1:0]     Blank,
  output logic                  Busy,
  output logic                  Valid
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADJUST = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Blank of digit 0 is never set so a zero result still shows one "0".
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  logic [1:0]          state_q, state_d;
  logic                start_q, start_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] scr_q, scr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  logic                start_ev;
  logic [DIGITS-1:0]   blank_calc;

  assign start_ev = Start & ~start_q;

  // Leading-zero flags from the finished scratch value, scanning from the top digit down.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (scr_q[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_run;
    end
  end

  // Next-state and datapath for the conversion sequencer.
  always_comb begin
    state_d = state_q;
    start_d = Start;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          sh_d    = Bin;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADJUST;
        end
      end
      S_ADJUST: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (scr_q[4*i +: 4] >= 4'd5) begin
            scr_d[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
          end
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {scr_d, sh_d} = {scr_q, sh_q} << 1;
        cnt_d         = cnt_q + 1'b1;
        state_d       = (cnt_q == CW'(WIDTH - 1)) ? S_DONE : S_ADJUST;
      end
      S_DONE: begin
        bcd_d   = scr_q;
        blank_d = blank_calc;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign Bcd   = bcd_q;
  assign Blank = blank_q;
  assign Busy  = busy_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_bin2bcd.sv
// Bench for bin2bcd: fixed vectors, multi-cycle corner sequences and
// random quotients checked against a decimal reference model.
module tb_bin2bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [11:0] Bin;
  logic [15:0] Bcd;
  logic [3:0]  Blank;
  logic        Busy;
  logic        Valid;

  int total = 0;
  int bad   = 0;

  bin2bcd #(.WIDTH(12), .DIGITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .Start(Start),
    .Bin  (Bin),
    .Bcd  (Bcd),
    .Blank(Blank),
    .Busy (Busy),
    .Valid(Valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Decimal digits by plain division.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i (i>=1) is blank when the value has fewer than i+1 decimal digits.
  function automatic logic [3:0] ref_blank(input int v);
    logic [3:0] b;
    b    = 4'b0000;
    b[1] = (v < 10);
    b[2] = (v < 100);
    b[3] = (v < 1000);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion; Bin is scrambled right after capture.
  task automatic run_conv(input int b, input string tag,
                          output logic [15:0] got_bcd, output logic [3:0] got_blank);
    int n;
    tick();
    Start = 1'b0;
    Bin   = 12'(b);
    tick();
    Start = 1'b1;
    tick();
    check({tag, "_busy_on"}, int'(Busy), 1);
    Start = 1'b0;
    Bin   = 12'($urandom_range(0, 4095));
    n = 0;
    while (!Valid && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 25);
    check({tag, "_busy_off"}, int'(Busy), 0);
    got_bcd   = Bcd;
    got_blank = Blank;
    tick();
    check({tag, "_valid_one_cycle"}, int'(Valid), 0);
  endtask

  initial begin
    logic [15:0] gb;
    logic [3:0]  gl;
    int busy_n, valid_n, n;

    vecs[0] = '{0,    16'h0000, 4'b1110};
    vecs[1] = '{4095, 16'h4095, 4'b0000};
    vecs[2] = '{100,  16'h0100, 4'b1000};
    vecs[3] = '{7,    16'h0007, 4'b1110};
    vecs[4] = '{1234, 16'h1234, 4'b0000};
    vecs[5] = '{999,  16'h0999, 4'b1000};
    vecs[6] = '{10,   16'h0010, 4'b1100};
    vecs[7] = '{9,    16'h0009, 4'b1110};

    // Reset with Start already high; first edge after release must start.
    rst_n = 1'b0;
    Start = 1'b1;
    Bin   = 12'd42;
    tick();
    tick();
    check("rst_bcd", int'(Bcd), 0);
    check("rst_blank", int'(Blank), 4'b1110);
    check("rst_busy", int'(Busy), 0);
    check("rst_valid", int'(Valid), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_start_busy", int'(Busy), 1);
    n = 0;
    while (!Valid && n < 60) begin
      tick();
      n++;
    end
    check("post_rst_latency", n, 25);
    check("post_rst_bcd", int'(Bcd), 16'h0042);
    Start = 1'b0;

    // Fixed vectors.
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, $sformatf("vec%0d", i), gb, gl);
      check($sformatf("vec%0d_bcd", i), int'(gb), int'(vecs[i].bcd));
      check($sformatf("vec%0d_blank", i), int'(gl), int'(vecs[i].blank));
      check($sformatf("vec%0d_hold", i), int'(Bcd), int'(vecs[i].bcd));
    end

    // Start held high for 60 cycles: one conversion only.
    tick();
    Start = 1'b0;
    Bin   = 12'd1234;
    tick();
    Start = 1'b1;
    busy_n = 0;
    valid_n = 0;
    gb = '0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (Busy) busy_n++;
      if (Valid) begin
        valid_n++;
        gb = Bcd;
      end
      if (i == 59) Start = 1'b0;
    end
    check("hold_busy_cycles", busy_n, 25);
    check("hold_valid_count", valid_n, 1);
    check("hold_bcd", int'(gb), 16'h1234);

    // Second start pulse mid-conversion is dropped.
    Bin = 12'd321;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    Bin   = 12'd876;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    valid_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Valid) begin
        valid_n++;
        gb = Bcd;
      end
    end
    check("ignore_valid_count", valid_n, 1);
    check("ignore_bcd", int'(gb), 16'h0321);

    // Reset in the middle of a conversion aborts it.
    Bin = 12'd999;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", int'(Busy), 0);
    check("abort_bcd", int'(Bcd), 0);
    check("abort_blank", int'(Blank), 4'b1110);
    check("abort_valid", int'(Valid), 0);
    valid_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (Valid) valid_n++;
    end
    check("abort_no_valid", valid_n, 0);
    run_conv(999, "after_abort", gb, gl);
    check("after_abort_bcd", int'(gb), 16'h0999);

    // Start rise coinciding with DONE is lost.
    Bin = 12'd55;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (24) tick();
    Start = 1'b1;
    tick();
    check("done_rise_valid", int'(Valid), 1);
    tick();
    check("done_rise_lost", int'(Busy), 0);
    repeat (5) tick();
    check("done_rise_still_idle", int'(Busy), 0);
    Start = 1'b0;

    // Start rise on the cycle after DONE is accepted.
    Bin = 12'd66;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (25) tick();
    check("after_done_valid", int'(Valid), 1);
    Start = 1'b1;
    Bin   = 12'd77;
    tick();
    check("after_done_accept", int'(Busy), 1);
    Start = 1'b0;
    n = 0;
    while (!Valid && n < 60) begin
      tick();
      n++;
    end
    check("after_done_latency", n, 25);
    check("after_done_bcd", int'(Bcd), 16'h0077);

    // Random divider quotients against the decimal model.
    for (int i = 0; i < 200; i++) begin
      int a, d, q;
      a = $urandom_range(0, 4095);
      d = $urandom_range(1, 4095);
      if (i % 4 == 0) d = $urandom_range(1, 3);
      q = a / d;
      run_conv(q, "rnd", gb, gl);
      check($sformatf("rnd%0d_bcd_q%0d", i, q), int'(gb), int'(ref_bcd(q)));
      check($sformatf("rnd%0d_blank_q%0d", i, q), int'(gl), int'(ref_blank(q)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
